flptadder_mantissa_arbiter: RTL

Round-robin scheduler that shares one combinational sign-magnitude mantissa add/sub datapath among NREQ requesters, one per FIR band of the 10-bit floating-point filter. It accepts operand pairs over a valid/ready handshake, drives the shared datapath from registered operands, and captures the result. It returns the result with a requester tag over a valid/ready handshake. The arbiter sits between the band accumulators and the single mantissa stage of the floating-point adder.

---
 rtl/flptadder_mantissa_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/flptadder_mantissa_arbiter.sv
// flptadder_mantissa_arbiter
// Round-robin scheduler that shares one combinational sign-magnitude mantissa
// add/sub datapath among NREQ band accumulators. Operands arrive on a per-
// requester valid/ready handshake. They are registered onto add_m1/add_m2.
// The datapath result is captured one cycle later and returned with the
// owning requester's tag on a valid/ready handshake.
// Optional feature: define FLPT_ARB_GRANT_CNT_EN to build per-requester
// saturating 8-bit grant counters on grant_cnt. Without the macro, grant_cnt
// is tied to zero.
module flptadder_mantissa_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TAG_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [6*NREQ-1:0]    req_m1,
  input  logic [6*NREQ-1:0]    req_m2,
  output logic [NREQ-1:0]      req_ready,
  output logic [5:0]           add_m1,
  output logic [5:0]           add_m2,
  input  logic [6:0]           add_sum,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [6:0]           rsp_sum,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 busy,
  output logic [8*NREQ-1:0]    grant_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TAG_W-1:0] last_grant;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] win_idx;
  logic             win_found;
  logic             accept;
  logic [31:0]      cand;
  logic [5:0]       sel_m1;
  logic [5:0]       sel_m2;

  // Round-robin search starting one past the last grant, wrapping modulo NREQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(last_grant) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!win_found && req_valid[cand[TAG_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[TAG_W-1:0];
      end
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    sel_m1 = '0;
    sel_m2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == TAG_W'(i)) begin
        sel_m1 = req_m1[6*i +: 6];
        sel_m2 = req_m2[6*i +: 6];
      end
    end
  end

  // Accept in IDLE, or in RESP when the result is being consumed; blocked during reset
  assign accept = rst_n && win_found &&
                  ((state == IDLE) || ((state == RESP) && rsp_ready));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = accept ? EXEC : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (accept && (win_idx == TAG_W'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Operand, tag and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_m1     <= '0;
      add_m2     <= '0;
      tag        <= '0;
      last_grant <= TAG_W'(NREQ - 1);
      rsp_sum    <= '0;
      rsp_tag    <= '0;
    end else begin
      if (accept) begin
        add_m1     <= sel_m1;
        add_m2     <= sel_m2;
        tag        <= win_idx;
        last_grant <= win_idx;
      end
      if (state == EXEC) begin
        rsp_sum <= add_sum;
        rsp_tag <= tag;
      end
    end
  end

`ifdef FLPT_ARB_GRANT_CNT_EN
  logic [8*NREQ-1:0] cnt;

  // Saturating per-requester grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_ready[i] && (cnt[8*i +: 8] != 8'hFF)) begin
          cnt[8*i +: 8] <= cnt[8*i +: 8] + 8'd1;
        end
      end
    end
  end

  assign grant_cnt = cnt;
`else
  assign grant_cnt = '0;
`endif

endmodule
